hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
- Central hazard controller for the 5-stage pipeline.
- Drives stall/flush on the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers, plus EX-stage forwarding selects.
- Sequences multi-cycle data-memory accesses with a wait-state FSM.
- Keeps a saturating stall-cycle performance counter.
- Sits beside the datapath and is fed by register addresses and control bits from the D, E, M and W stages.

Parameters:
- MEM_LAT, 3, data-memory access latency in cycles (legal 1..16; 1 = single-cycle, never stalls).
- PERF_W, 16, width of stall-cycle counter.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- rs1D_i  in  5  source reg 1 of instr in D.
- rs2D_i  in  5  source reg 2 of instr in D.
- rs1E_i  in  5  source reg 1 of instr in E.
- rs2E_i  in  5  source reg 2 of instr in E.
- rdE_i  in  5  dest reg of instr in E.
- rdM_i  in  5  dest reg of instr in M.
- rdW_i  in  5  dest reg of instr in W.
- memreadE_i  in  1  instr in E is a load.
- regwriteM_i  in  1  instr in M writes the register file.
- regwriteW_i  in  1  instr in W writes the register file.
- memreqM_i  in  1  instr in M accesses data memory (load or store).
- pcsrcE_i  in  1  taken branch/jump resolved in E.
- stallF_o  out  1  hold PC.
- stallD_o  out  1  hold IF/ID register.
- stallE_o  out  1  hold ID/EX register.
- stallM_o  out  1  hold EX/MEM register.
- flushD_o  out  1  clear IF/ID register.
- flushE_o  out  1  clear ID/EX register.
- flushW_o  out  1  clear MEM/WB register (bubble).
- fwdAE_o  out  2  operand A forward select.
- fwdBE_o  out  2  operand B forward select.
- stall_cnt_o  out  PERF_W  saturating count of cycles with stallF_o=1.

Behaviour:
- Reset is asynchronous, active-low on rst_i, single clock clk_i.
- While rst_i=0:
  - state=RUN, wait counter=0, stall_cnt_o=0.
  - All stall, flush and forward outputs are forced to 0.
- Forwarding (combinational), shown for A; B is identical using rs2E_i:
  - FWD_MEM (2'b10) if regwriteM_i && rdM_i!=0 && rdM_i==rs1E_i.
  - Otherwise FWD_WB (2'b01) if regwriteW_i && rdW_i!=0 && rdW_i==rs1E_i.
  - Otherwise FWD_NONE (2'b00).
  - The M match takes priority over W.
- Load-use detection:
  - lwstall = memreadE_i && rdE_i!=0 && (rdE_i==rs1D_i || rdE_i==rs2D_i).
- mem_stall generation:
  - RUN: if memreqM_i && MEM_LAT>1, then mem_stall=1, next state=WAIT, cnt<=MEM_LAT-2.
  - WAIT, cnt!=0: mem_stall=1, cnt<=cnt-1.
  - WAIT, cnt==0: mem_stall=0, next state=RUN. The access completes and the instr leaves M on this edge.
  - Total stall per access = MEM_LAT-1 cycles. Back-to-back memory instrs each pay the full latency.
- Output priority (highest first):
  - mem_stall=1: stallF/D/E/M=1, flushW=1, flushD=flushE=0. A pending pcsrcE_i or lwstall is held off, not lost; E is frozen, so it re-evaluates when the stall drops.
  - pcsrcE_i=1: flushD=1, flushE=1, all stalls 0.
  - lwstall=1: stallF=1, stallD=1, flushE=1. This is exactly one bubble, since the load moves to M next cycle.
  - Otherwise: all stall and flush outputs 0.
- stall_cnt_o increments on every clock with stallF_o=1 and saturates at all-ones.
- Reset mid-WAIT returns to RUN immediately. No partial count is retained.
- Register 0 never forwards and never causes a load-use stall.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_e enum: FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - hz_state_e enum: RUN, WAIT.
  - Constant REG_ZERO=5'd0.
- Sub-module forward_unit: purely combinational forwarding-select logic, instantiated once with both operand paths. The FSM, priority logic and counter stay in the top.

Test Plan:
1. rdM_i=5, regwriteM_i=1, rdW_i=5, regwriteW_i=1, rs1E_i=5, rs2E_i=0 -> fwdAE_o=2'b10, fwdBE_o=2'b00.
2. memreadE_i=1, rdE_i=7, rs2D_i=7 for one cycle -> stallF/D=1 and flushE=1 for exactly 1 cycle; stall_cnt_o increments by 1. Repeat with rdE_i=0 -> no stall.
3. pcsrcE_i=1, no memreq -> flushD=flushE=1 for that cycle only; stall outputs 0.
4. MEM_LAT=3, memreqM_i=1 pulse -> stallF/D/E/M and flushW=1 for exactly 2 cycles, then 0; stall_cnt_o=2. With MEM_LAT=1 -> never stalls.
5. memreqM_i=1 while pcsrcE_i=1 held -> flushD/E=0 during 2 stall cycles, then flushD/E=1 on the first non-stall cycle.
6. Assert rst_i=0 during WAIT -> all outputs 0 at once. After release, state is RUN and stall_cnt_o=0. Force 65535 stall cycles -> stall_cnt_o holds 16'hFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// The forwarding priority lives here so it is written once for both operands.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_WB   = 2'b01,
      FWD_MEM  = 2'b10
   } fwd_sel_e;

   typedef enum logic {
      RUN  = 1'b0,
      WAIT = 1'b1
   } hz_state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // The younger producer in M wins over W; x0 is hardwired and never forwards.
   function automatic fwd_sel_e fwd_pick(
      input logic [4:0] rs,
      input logic [4:0] rd_m,
      input logic       we_m,
      input logic [4:0] rd_w,
      input logic       we_w
   );
      fwd_sel_e sel;
      if (we_m && (rd_m != REG_ZERO) && (rd_m == rs)) begin
         sel = FWD_MEM;
      end else if (we_w && (rd_w != REG_ZERO) && (rd_w == rs)) begin
         sel = FWD_WB;
      end else begin
         sel = FWD_NONE;
      end
      return sel;
   endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational EX-stage operand forwarding selects for both source operands.
module forward_unit
   import hazard_pkg::*;
(
   input  logic [4:0] rs1E_i,
   input  logic [4:0] rs2E_i,
   input  logic [4:0] rdM_i,
   input  logic [4:0] rdW_i,
   input  logic       regwriteM_i,
   input  logic       regwriteW_i,
   output logic [1:0] fwdA_o,
   output logic [1:0] fwdB_o
);

   // Forward select for operand A and operand B
   always_comb begin
      fwdA_o = fwd_pick(rs1E_i, rdM_i, regwriteM_i, rdW_i, regwriteW_i);
      fwdB_o = fwd_pick(rs2E_i, rdM_i, regwriteM_i, rdW_i, regwriteW_i);
   end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Central hazard controller: stall/flush generation, data-memory wait-state
// sequencing, EX forwarding selects and a saturating stall-cycle counter.
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int MEM_LAT = 3,
   parameter int PERF_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [4:0]        rs1D_i,
   input  logic [4:0]        rs2D_i,
   input  logic [4:0]        rs1E_i,
   input  logic [4:0]        rs2E_i,
   input  logic [4:0]        rdE_i,
   input  logic [4:0]        rdM_i,
   input  logic [4:0]        rdW_i,
   input  logic              memreadE_i,
   input  logic              regwriteM_i,
   input  logic              regwriteW_i,
   input  logic              memreqM_i,
   input  logic              pcsrcE_i,
   output logic              stallF_o,
   output logic              stallD_o,
   output logic              stallE_o,
   output logic              stallM_o,
   output logic              flushD_o,
   output logic              flushE_o,
   output logic              flushW_o,
   output logic [1:0]        fwdAE_o,
   output logic [1:0]        fwdBE_o,
   output logic [PERF_W-1:0] stall_cnt_o
);

   localparam int               CNT_W       = 5;
   localparam logic [CNT_W-1:0] WAIT_INIT   = CNT_W'(MEM_LAT - 2);
   localparam logic             MULTI_CYCLE = (MEM_LAT > 1);
   localparam logic [PERF_W-1:0] PERF_MAX   = {PERF_W{1'b1}};

   hz_state_e        r_state;
   hz_state_e        w_state_nxt;
   logic [CNT_W-1:0] r_wait_cnt;
   logic [CNT_W-1:0] w_wait_cnt_nxt;
   logic [PERF_W-1:0] r_stall_cnt;
   logic             w_mem_stall;
   logic             w_lwstall;
   logic [1:0]       w_fwdA;
   logic [1:0]       w_fwdB;

   forward_unit u_forward_unit (
      .rs1E_i      (rs1E_i),
      .rs2E_i      (rs2E_i),
      .rdM_i       (rdM_i),
      .rdW_i       (rdW_i),
      .regwriteM_i (regwriteM_i),
      .regwriteW_i (regwriteW_i),
      .fwdA_o      (w_fwdA),
      .fwdB_o      (w_fwdB)
   );

   assign w_lwstall = memreadE_i && (rdE_i != REG_ZERO) &&
                      ((rdE_i == rs1D_i) || (rdE_i == rs2D_i));

   // Wait-state sequencing: the access stalls MEM_LAT-1 cycles, then leaves M
   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      w_mem_stall    = 1'b0;
      case (r_state)
         RUN: begin
            if (memreqM_i && MULTI_CYCLE) begin
               w_mem_stall    = 1'b1;
               w_state_nxt    = WAIT;
               w_wait_cnt_nxt = WAIT_INIT;
            end else begin
               w_state_nxt = RUN;
            end
         end
         WAIT: begin
            if (r_wait_cnt != {CNT_W{1'b0}}) begin
               w_mem_stall    = 1'b1;
               w_wait_cnt_nxt = r_wait_cnt - CNT_W'(1);
            end else begin
               w_state_nxt = RUN;
            end
         end
         default: begin
            w_state_nxt    = RUN;
            w_wait_cnt_nxt = {CNT_W{1'b0}};
         end
      endcase
   end

   // Stall/flush priority; a held-off branch or load-use re-evaluates once E unfreezes
   always_comb begin
      stallF_o = 1'b0;
      stallD_o = 1'b0;
      stallE_o = 1'b0;
      stallM_o = 1'b0;
      flushD_o = 1'b0;
      flushE_o = 1'b0;
      flushW_o = 1'b0;
      fwdAE_o  = 2'b00;
      fwdBE_o  = 2'b00;
      if (rst_i) begin
         fwdAE_o = w_fwdA;
         fwdBE_o = w_fwdB;
         if (w_mem_stall) begin
            stallF_o = 1'b1;
            stallD_o = 1'b1;
            stallE_o = 1'b1;
            stallM_o = 1'b1;
            flushW_o = 1'b1;
         end else if (pcsrcE_i) begin
            flushD_o = 1'b1;
            flushE_o = 1'b1;
         end else if (w_lwstall) begin
            stallF_o = 1'b1;
            stallD_o = 1'b1;
            flushE_o = 1'b1;
         end else begin
            flushW_o = 1'b0;
         end
      end else begin
         fwdAE_o = 2'b00;
         fwdBE_o = 2'b00;
      end
   end

   // State, wait counter and saturating stall-cycle counter
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state     <= RUN;
         r_wait_cnt  <= {CNT_W{1'b0}};
         r_stall_cnt <= {PERF_W{1'b0}};
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
         if (stallF_o && (r_stall_cnt != PERF_MAX)) begin
            r_stall_cnt <= r_stall_cnt + PERF_W'(1);
         end else begin
            r_stall_cnt <= r_stall_cnt;
         end
      end
   end

   assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: directed scenarios plus randomized traffic
// against a cycle-indexed access model, on MEM_LAT=3 and MEM_LAT=1 instances.
module tb_hazard_ctrl_unit;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic       rst_i;
   logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
   logic       memreadE, regwriteM, regwriteW, memreqM, pcsrcE;

   logic        sFa, sDa, sEa, sMa, fDa, fEa, fWa;
   logic        sFb, sDb, sEb, sMb, fDb, fEb, fWb;
   logic [1:0]  fwdAa, fwdBa, fwdAb, fwdBb;
   logic [15:0] cnt_a, cnt_b;

   wire [6:0] ctrl_a = {sFa, sDa, sEa, sMa, fDa, fEa, fWa};
   wire [6:0] ctrl_b = {sFb, sDb, sEb, sMb, fDb, fEb, fWb};

   hazard_ctrl_unit #(.MEM_LAT(3), .PERF_W(16)) u_dut_a (
      .clk_i(clk_i), .rst_i(rst_i),
      .rs1D_i(rs1D), .rs2D_i(rs2D), .rs1E_i(rs1E), .rs2E_i(rs2E),
      .rdE_i(rdE), .rdM_i(rdM), .rdW_i(rdW),
      .memreadE_i(memreadE), .regwriteM_i(regwriteM), .regwriteW_i(regwriteW),
      .memreqM_i(memreqM), .pcsrcE_i(pcsrcE),
      .stallF_o(sFa), .stallD_o(sDa), .stallE_o(sEa), .stallM_o(sMa),
      .flushD_o(fDa), .flushE_o(fEa), .flushW_o(fWa),
      .fwdAE_o(fwdAa), .fwdBE_o(fwdBa), .stall_cnt_o(cnt_a)
   );

   hazard_ctrl_unit #(.MEM_LAT(1), .PERF_W(16)) u_dut_b (
      .clk_i(clk_i), .rst_i(rst_i),
      .rs1D_i(rs1D), .rs2D_i(rs2D), .rs1E_i(rs1E), .rs2E_i(rs2E),
      .rdE_i(rdE), .rdM_i(rdM), .rdW_i(rdW),
      .memreadE_i(memreadE), .regwriteM_i(regwriteM), .regwriteW_i(regwriteW),
      .memreqM_i(memreqM), .pcsrcE_i(pcsrcE),
      .stallF_o(sFb), .stallD_o(sDb), .stallE_o(sEb), .stallM_o(sMb),
      .flushD_o(fDb), .flushE_o(fEb), .flushW_o(fWb),
      .fwdAE_o(fwdAb), .fwdBE_o(fwdBb), .stall_cnt_o(cnt_b)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model: acc_k = cycle index inside the current memory access, -1 when idle.
   int lat_m [2];
   int acc_k [2];
   int cnt_m [2];

   localparam logic [6:0] C_NONE = 7'b0000000;
   localparam logic [6:0] C_MEM  = 7'b1111001;
   localparam logic [6:0] C_BR   = 7'b0000110;
   localparam logic [6:0] C_LW   = 7'b1100010;

   function automatic logic model_mem_stall(int idx);
      if (acc_k[idx] >= 0) return (acc_k[idx] < lat_m[idx] - 1);
      return memreqM && (lat_m[idx] > 1);
   endfunction

   function automatic logic [6:0] exp_ctrl(int idx);
      logic lw;
      lw = memreadE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));
      if (!rst_i) return C_NONE;
      if (model_mem_stall(idx)) return C_MEM;
      if (pcsrcE) return C_BR;
      if (lw) return C_LW;
      return C_NONE;
   endfunction

   function automatic logic [1:0] exp_fwd(logic [4:0] rs);
      if (!rst_i) return 2'b00;
      if (regwriteM && rdM != 5'd0 && rdM == rs) return 2'b10;
      if (regwriteW && rdW != 5'd0 && rdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic clear_inputs();
      rs1D = 5'd0; rs2D = 5'd0; rs1E = 5'd0; rs2E = 5'd0;
      rdE = 5'd0; rdM = 5'd0; rdW = 5'd0;
      memreadE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
      memreqM = 1'b0; pcsrcE = 1'b0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         acc_k[i] = -1;
         cnt_m[i] = 0;
      end
   endtask

   task automatic tick();
      logic stall_now [2];
      logic start_now [2];
      for (int i = 0; i < 2; i++) begin
         stall_now[i] = exp_ctrl(i) == C_MEM || exp_ctrl(i) == C_LW;
         start_now[i] = (acc_k[i] < 0) && memreqM && (lat_m[i] > 1);
      end
      @(posedge clk_i);
      if (rst_i) begin
         for (int i = 0; i < 2; i++) begin
            if (stall_now[i] && cnt_m[i] < 65535) cnt_m[i] = cnt_m[i] + 1;
            if (acc_k[i] >= 0) acc_k[i] = (acc_k[i] == lat_m[i] - 1) ? -1 : acc_k[i] + 1;
            else if (start_now[i]) acc_k[i] = 1;
         end
      end
      #1;
   endtask

   task automatic apply_reset();
      rst_i = 1'b0;
      clear_inputs();
      model_reset();
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      model_reset();
      memreqM = 1'b1; pcsrcE = 1'b1; memreadE = 1'b1; rdE = 5'd3; rs1D = 5'd3;
      regwriteM = 1'b1; rdM = 5'd4; rs1E = 5'd4; rs2E = 5'd4;
      #1;
      n_tests++;
      if (ctrl_a !== C_NONE) begin n_fail++; $display("FAIL reset_ctrl: got %b expected %b", ctrl_a, C_NONE); end
      n_tests++;
      if ({fwdAa, fwdBa} !== 4'b0000) begin n_fail++; $display("FAIL reset_fwd: got %b expected 0000", {fwdAa, fwdBa}); end
      n_tests++;
      if (cnt_a !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt_a); end
      apply_reset();
   endtask

   task automatic test_forwarding();
      apply_reset();
      regwriteM = 1'b1; rdM = 5'd5; regwriteW = 1'b1; rdW = 5'd5; rs1E = 5'd5; rs2E = 5'd0;
      #1;
      n_tests++;
      if ({fwdAa, fwdBa} !== 4'b1000) begin n_fail++; $display("FAIL fwd_m_priority: got %b expected 1000", {fwdAa, fwdBa}); end
      rdW = 5'd6; rs2E = 5'd6;
      #1;
      n_tests++;
      if ({fwdAa, fwdBa} !== 4'b1001) begin n_fail++; $display("FAIL fwd_wb: got %b expected 1001", {fwdAa, fwdBa}); end
      rdM = 5'd0; rs1E = 5'd0; rdW = 5'd0; rs2E = 5'd0;
      #1;
      n_tests++;
      if ({fwdAa, fwdBa} !== 4'b0000) begin n_fail++; $display("FAIL fwd_x0: got %b expected 0000", {fwdAa, fwdBa}); end
      clear_inputs();
   endtask

   task automatic test_load_use();
      apply_reset();
      memreadE = 1'b1; rdE = 5'd7; rs2D = 5'd7;
      #1;
      n_tests++;
      if (ctrl_a !== C_LW) begin n_fail++; $display("FAIL lw_stall: got %b expected %b", ctrl_a, C_LW); end
      tick();
      clear_inputs();
      #1;
      n_tests++;
      if (ctrl_a !== C_NONE) begin n_fail++; $display("FAIL lw_one_bubble: got %b expected %b", ctrl_a, C_NONE); end
      n_tests++;
      if (cnt_a !== 16'd1) begin n_fail++; $display("FAIL lw_cnt: got %0d expected 1", cnt_a); end
      memreadE = 1'b1; rdE = 5'd0; rs1D = 5'd0; rs2D = 5'd0;
      #1;
      n_tests++;
      if (ctrl_a !== C_NONE) begin n_fail++; $display("FAIL lw_x0: got %b expected %b", ctrl_a, C_NONE); end
      tick();
      n_tests++;
      if (cnt_a !== 16'd1) begin n_fail++; $display("FAIL lw_x0_cnt: got %0d expected 1", cnt_a); end
      clear_inputs();
   endtask

   task automatic test_branch_flush();
      apply_reset();
      pcsrcE = 1'b1;
      #1;
      n_tests++;
      if (ctrl_a !== C_BR) begin n_fail++; $display("FAIL branch_flush: got %b expected %b", ctrl_a, C_BR); end
      tick();
      pcsrcE = 1'b0;
      #1;
      n_tests++;
      if (ctrl_a !== C_NONE) begin n_fail++; $display("FAIL branch_one_cycle: got %b expected %b", ctrl_a, C_NONE); end
   endtask

   task automatic test_mem_stall();
      logic [6:0] exp_seq [3];
      exp_seq[0] = C_MEM; exp_seq[1] = C_MEM; exp_seq[2] = C_NONE;
      apply_reset();
      memreqM = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_tests++;
         if (ctrl_a !== exp_seq[i]) begin n_fail++; $display("FAIL mem_stall_c%0d: got %b expected %b", i, ctrl_a, exp_seq[i]); end
         n_tests++;
         if (ctrl_b !== C_NONE) begin n_fail++; $display("FAIL mem_lat1_c%0d: got %b expected %b", i, ctrl_b, C_NONE); end
         tick();
         memreqM = 1'b0;
      end
      #1;
      n_tests++;
      if (cnt_a !== 16'd2) begin n_fail++; $display("FAIL mem_cnt: got %0d expected 2", cnt_a); end
      n_tests++;
      if (cnt_b !== 16'd0) begin n_fail++; $display("FAIL mem_lat1_cnt: got %0d expected 0", cnt_b); end
   endtask

   task automatic test_mem_vs_branch();
      logic [6:0] exp_seq [3];
      exp_seq[0] = C_MEM; exp_seq[1] = C_MEM; exp_seq[2] = C_BR;
      apply_reset();
      memreqM = 1'b1; pcsrcE = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_tests++;
         if (ctrl_a !== exp_seq[i]) begin n_fail++; $display("FAIL mem_vs_branch_c%0d: got %b expected %b", i, ctrl_a, exp_seq[i]); end
         tick();
         memreqM = 1'b0;
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid_wait();
      apply_reset();
      memreqM = 1'b1;
      #1;
      tick();
      memreqM = 1'b0; pcsrcE = 1'b1; regwriteM = 1'b1; rdM = 5'd9; rs1E = 5'd9;
      #1;
      n_tests++;
      if (ctrl_a !== C_MEM) begin n_fail++; $display("FAIL wait_before_rst: got %b expected %b", ctrl_a, C_MEM); end
      rst_i = 1'b0;
      model_reset();
      #1;
      n_tests++;
      if ({ctrl_a, fwdAa, fwdBa} !== 11'd0) begin n_fail++; $display("FAIL rst_mid_wait_out: got %b expected 0", {ctrl_a, fwdAa, fwdBa}); end
      n_tests++;
      if (cnt_a !== 16'd0) begin n_fail++; $display("FAIL rst_mid_wait_cnt: got %0d expected 0", cnt_a); end
      @(posedge clk_i);
      #2;
      rst_i = 1'b1;
      clear_inputs();
      memreqM = 1'b1;
      #1;
      n_tests++;
      if (ctrl_a !== C_MEM) begin n_fail++; $display("FAIL rst_run_entry: got %b expected %b", ctrl_a, C_MEM); end
      tick();
      memreqM = 1'b0;
      tick();
      tick();
      n_tests++;
      if (cnt_a !== 16'd2) begin n_fail++; $display("FAIL rst_fresh_cnt: got %0d expected 2", cnt_a); end
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 3000; c++) begin
         rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
         rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
         rdE  = 5'($urandom_range(0, 3)); rdM  = 5'($urandom_range(0, 3));
         rdW  = 5'($urandom_range(0, 3));
         memreadE  = ($urandom_range(0, 2) == 0);
         regwriteM = ($urandom_range(0, 1) == 0);
         regwriteW = ($urandom_range(0, 1) == 0);
         memreqM   = ($urandom_range(0, 3) == 0);
         pcsrcE    = ($urandom_range(0, 7) == 0);
         #1;
         n_tests++;
         if (ctrl_a !== exp_ctrl(0) || ctrl_b !== exp_ctrl(1)) begin
            n_fail++;
            $display("FAIL rand_ctrl c%0d: got %b/%b expected %b/%b", c, ctrl_a, ctrl_b, exp_ctrl(0), exp_ctrl(1));
         end
         n_tests++;
         if (fwdAa !== exp_fwd(rs1E) || fwdBa !== exp_fwd(rs2E) || fwdAb !== exp_fwd(rs1E) || fwdBb !== exp_fwd(rs2E)) begin
            n_fail++;
            $display("FAIL rand_fwd c%0d: got %b%b expected %b%b", c, fwdAa, fwdBa, exp_fwd(rs1E), exp_fwd(rs2E));
         end
         n_tests++;
         if (int'(cnt_a) != cnt_m[0] || int'(cnt_b) != cnt_m[1]) begin
            n_fail++;
            $display("FAIL rand_cnt c%0d: got %0d/%0d expected %0d/%0d", c, cnt_a, cnt_b, cnt_m[0], cnt_m[1]);
         end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_saturation();
      apply_reset();
      memreadE = 1'b1; rdE = 5'd7; rs1D = 5'd7;
      for (int i = 0; i < 65540; i++) begin
         if (i == 65534) begin
            n_tests++;
            if (cnt_a !== 16'd65534) begin n_fail++; $display("FAIL sat_pre: got %0d expected 65534", cnt_a); end
         end
         tick();
      end
      n_tests++;
      if (cnt_a !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h expected ffff", cnt_a); end
      n_tests++;
      if (int'(cnt_b) != cnt_m[1]) begin n_fail++; $display("FAIL sat_hold_b: got %0d expected %0d", cnt_b, cnt_m[1]); end
      clear_inputs();
   endtask

   initial begin
      lat_m[0] = 3;
      lat_m[1] = 1;
      clear_inputs();
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch_flush();
      test_mem_stall();
      test_mem_vs_branch();
      test_reset_mid_wait();
      test_random();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
